// File: rtl/uart_rx_edge_bit_sampler_if.sv
// Signal bundle between the RX control FSM (master) and the edge/bit sampler (slave).
interface uart_rx_edge_bit_sampler_if #(
    parameter int PRESC_W = 6
);
    logic               RX_IN;
    logic               edge_bit_en;
    logic               dat_samp_en;
    logic               par_en;
    logic [PRESC_W-1:0] pre_scale;
    logic [PRESC_W-1:0] edge_cnt;
    logic [3:0]         bit_cnt;
    logic               sampled_bit;
    logic               sample_valid;
    logic               cfg_err;

    modport master (
        output RX_IN, edge_bit_en, dat_samp_en, par_en, pre_scale,
        input  edge_cnt, bit_cnt, sampled_bit, sample_valid, cfg_err
    );

    modport slave (
        input  RX_IN, edge_bit_en, dat_samp_en, par_en, pre_scale,
        output edge_cnt, bit_cnt, sampled_bit, sample_valid, cfg_err
    );
endinterface

// File: rtl/uart_rx_edge_bit_sampler.sv
// UART RX timing front end: oversampling edge/bit counters and 3-sample majority vote.
module uart_rx_edge_bit_sampler #(
    parameter int DATA_BITS = 8,
    parameter int PRESC_W   = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_rx_edge_bit_sampler_if.slave bus
);
    localparam logic [PRESC_W-1:0] P_DEF = PRESC_W'(8);

    logic [PRESC_W-1:0] p_q;
    logic [PRESC_W-1:0] p_last;
    logic [PRESC_W-1:0] mid;
    logic [PRESC_W-1:0] edge_q;
    logic [3:0]         bit_q;
    logic [3:0]         last;
    logic [1:0]         samp_q;
    logic [1:0]         taken_q;
    logic               sbit_q;
    logic               valid_q;
    logic               cfg_err_q;
    logic               legal;
    logic               wrap;
    logic               vote;

    always_comb begin
        legal  = (bus.pre_scale == PRESC_W'(8))  ||
                 (bus.pre_scale == PRESC_W'(16)) ||
                 (bus.pre_scale == PRESC_W'(32));
        p_last = p_q - 1'b1;
        mid    = p_q >> 1;
        last   = 4'(DATA_BITS + 1) + {3'b000, bus.par_en};
        wrap   = (edge_q == p_last);
        // Third sample is the live RX_IN on the vote clock, so only two are stored.
        vote   = (samp_q[1] & samp_q[0]) | (samp_q[1] & bus.RX_IN) |
                 (samp_q[0] & bus.RX_IN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q       <= P_DEF;
            cfg_err_q <= 1'b0;
            edge_q    <= '0;
            bit_q     <= '0;
            samp_q    <= '1;
            taken_q   <= '0;
            sbit_q    <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;

            if (!bus.edge_bit_en) begin
                edge_q <= '0;
                bit_q  <= '0;
                if (legal) begin
                    p_q       <= bus.pre_scale;
                    cfg_err_q <= 1'b0;
                end else begin
                    p_q       <= P_DEF;
                    cfg_err_q <= 1'b1;
                end
            end else if (wrap) begin
                edge_q <= '0;
                if (bit_q < last)
                    bit_q <= bit_q + 1'b1;
            end else begin
                edge_q <= edge_q + 1'b1;
            end

            // taken_q tracks an unbroken run of samples so a gap abandons the vote.
            if (!bus.dat_samp_en) begin
                samp_q  <= '1;
                taken_q <= '0;
            end else if (edge_q == mid - 1'b1) begin
                samp_q  <= {samp_q[0], bus.RX_IN};
                taken_q <= 2'd1;
            end else if (edge_q == mid) begin
                samp_q  <= {samp_q[0], bus.RX_IN};
                taken_q <= (taken_q == 2'd1) ? 2'd2 : 2'd0;
            end else if (edge_q == mid + 1'b1) begin
                samp_q  <= {samp_q[0], bus.RX_IN};
                taken_q <= '0;
                if (taken_q == 2'd2) begin
                    sbit_q  <= vote;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.edge_cnt     = edge_q;
    assign bus.bit_cnt      = bit_q;
    assign bus.sampled_bit  = sbit_q;
    assign bus.sample_valid = valid_q;
    assign bus.cfg_err      = cfg_err_q;
endmodule

// File: tb/tb_uart_rx_edge_bit_sampler.sv
// Directed self-checking bench for uart_rx_edge_bit_sampler.
module tb_uart_rx_edge_bit_sampler;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    uart_rx_edge_bit_sampler_if #(.PRESC_W(6)) bus ();

    uart_rx_edge_bit_sampler #(.DATA_BITS(8), .PRESC_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.edge_bit_en = 1'b0;
        bus.dat_samp_en = 1'b0;
        bus.RX_IN       = 1'b1;
        repeat (n) step();
    endtask

    // Drives one frame of nb bits, then one extra bit with sampling off to show saturation.
    task automatic run_frame(input int p, input int nb, input logic [15:0] fb, input int last);
        int pulses;
        int ebit;
        logic exp_v;
        pulses = 0;
        bus.edge_bit_en = 1'b1;
        for (int i = 0; i < (nb + 1) * p; i++) begin
            bus.dat_samp_en = (i < nb * p);
            bus.RX_IN       = (i < nb * p) ? fb[i / p] : 1'b1;
            ebit  = (i / p > last) ? last : i / p;
            exp_v = (i > 0) && ((i - 1) % p == p / 2 + 1) && ((i - 1) / p < nb);
            chk("edge_cnt", bus.edge_cnt, i % p);
            chk("bit_cnt", bus.bit_cnt, ebit);
            chk("sample_valid", bus.sample_valid, exp_v);
            if (exp_v) chk("sampled_bit", bus.sampled_bit, fb[(i - 1) / p]);
            if (bus.sample_valid) pulses++;
            step();
        end
        chk("pulse_count", pulses, nb);
    endtask

    task automatic one_bit(input int p, input logic [31:0] pat, input logic exp_bit, input string tag);
        for (int c = 0; c < p; c++) begin
            bus.RX_IN = pat[c];
            step();
            if (c == p / 2 + 1) begin
                chk({tag, "_valid"}, bus.sample_valid, 1'b1);
                chk({tag, "_bit"}, bus.sampled_bit, exp_bit);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.RX_IN       = 1'b1;
        bus.edge_bit_en = 1'b0;
        bus.dat_samp_en = 1'b0;
        bus.par_en      = 1'b0;
        bus.pre_scale   = 6'd8;
        step();
        step();
        chk("rst_edge_cnt", bus.edge_cnt, 0);
        chk("rst_bit_cnt", bus.bit_cnt, 0);
        chk("rst_sampled_bit", bus.sampled_bit, 1);
        chk("rst_sample_valid", bus.sample_valid, 0);
        chk("rst_cfg_err", bus.cfg_err, 0);
        rst = 1'b0;
        idle(2);

        // P=8, no parity, 0x55
        run_frame(8, 10, {6'h3F, 1'b1, 8'h55, 1'b0}, 9);
        idle(2);

        // Glitch rejection at P=8
        bus.edge_bit_en = 1'b1;
        bus.dat_samp_en = 1'b1;
        one_bit(8, 32'h0000_0000, 1'b0, "zero");
        one_bit(8, 32'hFFFF_FFEF, 1'b1, "glitch1");
        one_bit(8, 32'hFFFF_FFCF, 1'b0, "glitch2");
        idle(2);

        // P=16 with parity: 11-bit frame
        bus.par_en    = 1'b1;
        bus.pre_scale = 6'd16;
        idle(2);
        run_frame(16, 11, {5'h1F, 1'b1, 1'b0, 8'hA3, 1'b0}, 10);
        chk("cfg_err_p16", bus.cfg_err, 0);
        bus.par_en = 1'b0;
        idle(2);

        // Illegal prescale falls back to 8
        bus.pre_scale = 6'd12;
        idle(1);
        chk("cfg_err_set", bus.cfg_err, 1);
        run_frame(8, 10, {6'h3F, 1'b1, 8'h3C, 1'b0}, 9);
        chk("cfg_err_frame", bus.cfg_err, 1);
        bus.pre_scale = 6'd32;
        idle(1);
        chk("cfg_err_clear", bus.cfg_err, 0);
        run_frame(32, 10, {6'h3F, 1'b1, 8'h0F, 1'b0}, 9);
        bus.pre_scale = 6'd8;
        idle(2);

        // Reset mid-frame at a sample point
        bus.edge_bit_en = 1'b1;
        bus.dat_samp_en = 1'b1;
        bus.RX_IN       = 1'b0;
        repeat (37) step();
        chk("pre_rst_edge", bus.edge_cnt, 5);
        chk("pre_rst_bit", bus.bit_cnt, 4);
        chk("pre_rst_sbit", bus.sampled_bit, 0);
        rst = 1'b1;
        step();
        chk("mid_rst_edge", bus.edge_cnt, 0);
        chk("mid_rst_bit", bus.bit_cnt, 0);
        chk("mid_rst_sbit", bus.sampled_bit, 1);
        chk("mid_rst_valid", bus.sample_valid, 0);
        rst = 1'b0;
        idle(2);

        // edge_bit_en drop coinciding with a wrap
        bus.edge_bit_en = 1'b1;
        bus.RX_IN       = 1'b1;
        repeat (23) step();
        chk("pre_drop_edge", bus.edge_cnt, 7);
        chk("pre_drop_bit", bus.bit_cnt, 2);
        bus.edge_bit_en = 1'b0;
        step();
        chk("drop_bit", bus.bit_cnt, 0);
        chk("drop_edge", bus.edge_cnt, 0);
        idle(2);

        // dat_samp_en gap at edge M abandons the vote
        bus.edge_bit_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.RX_IN       = (i < 8) ? 1'b0 : 1'b1;
            bus.dat_samp_en = (i != 12);
            chk("gap_valid", bus.sample_valid, i == 6);
            if (i == 6) chk("gap_first_bit", bus.sampled_bit, 0);
            step();
        end
        chk("gap_valid_end", bus.sample_valid, 0);
        chk("gap_sbit_hold", bus.sampled_bit, 0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
